i2c_arbiter: RTL and testbench



---
 rtl/i2c_arb_pkg.sv | 17 +
 rtl/i2c_arbiter_rr_picker.sv | 38 +++
 rtl/i2c_arbiter.sv | 140 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared definitions for the i2c engine arbiter.
//   arb_state_t            - arbiter FSM encoding (IDLE, ISSUE, WAIT_DONE, RESPOND)
//   I2C_WORD_W             - width of one {reg_addr, reg_data} write word
//   DEFAULT_TIMEOUT_CYCLES - default watchdog budget from engine accept to done
package i2c_arb_pkg;

  localparam int I2C_WORD_W             = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req       - request vector, one bit per requester
//   last_idx  - index of the previous winner; the search starts one above it
//   grant     - one-hot winner (all zero when no request is pending)
//   grant_idx - binary index of the winner
//   any       - high when some request is pending
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Walk the requesters starting at last_idx+1 and wrapping to 0; the first
  // pending one wins. last_idx itself is visited last, which bounds the wait
  // of a continuously requesting source to NUM_REQ-1 other transactions.
  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c write engine among NUM_REQ requesters.
//   clk_i, reset_i   - single clock, synchronous active-high reset
//   req_valid_i      - per-requester request
//   req_data_i       - packed request words, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o      - one-hot accept strobe (only while idle)
//   req_done_o       - one-cycle completion pulse to the owning requester
//   req_error_o      - error qualifier for req_done_o
//   eng_valid_o/eng_data_o/eng_ready_i - transaction handoff to the engine
//   eng_done_i/eng_error_i             - engine completion and NACK status
//   grant_o          - one-hot current owner, zero when idle
//   busy_o           - arbiter is not idle
//   timeout_o        - sticky watchdog expiry flag
//   err_count_o      - saturating count of errored transactions
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = I2C_WORD_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          req_done_o,
  output logic                        req_error_o,
  output logic                        eng_valid_o,
  output logic [DATA_W-1:0]           eng_data_o,
  input  logic                        eng_ready_i,
  input  logic                        eng_done_i,
  input  logic                        eng_error_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        timeout_o,
  output logic [ERR_CNT_W-1:0]        err_count_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_ISSUE     = ISSUE;
  localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;
  localparam logic [1:0] ST_RESPOND   = RESPOND;

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_word;
  logic [TIMER_W-1:0] timer;
  logic               captured_error;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid_i),
    .last_idx  (last_grant),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Word of the current round-robin winner, latched on acceptance.
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_word = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  // Handshake outputs decode directly from the state so ready, valid and the
  // done pulse line up with the state they belong to without extra latency.
  assign req_ready_o = (state == ST_IDLE) ? pick_grant : '0;
  assign eng_valid_o = (state == ST_ISSUE);
  assign req_done_o  = (state == ST_RESPOND) ? grant_o : '0;
  assign req_error_o = (state == ST_RESPOND) && captured_error;
  assign busy_o      = (state != ST_IDLE);

  // Main FSM. The watchdog is armed only once the engine has taken the word,
  // so a stalled eng_ready_i never causes a timeout. A done pulse in the same
  // cycle the timer hits zero takes priority over the timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      last_grant     <= LAST_INIT;
      grant_o        <= '0;
      eng_data_o     <= '0;
      timer          <= '0;
      captured_error <= 1'b0;
      timeout_o      <= 1'b0;
      err_count_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            eng_data_o <= pick_word;
            grant_o    <= pick_grant;
            last_grant <= pick_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (eng_ready_i) begin
            timer <= TIMER_LOAD;
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (eng_done_i) begin
            captured_error <= eng_error_i;
            state          <= ST_RESPOND;
          end else if (timer == '0) begin
            captured_error <= 1'b1;
            timeout_o      <= 1'b1;
            state          <= ST_RESPOND;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_RESPOND: begin
          if (captured_error && (err_count_o != '1)) begin
            err_count_o <= err_count_o + 1'b1;
          end
          grant_o <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scoreboard bench for i2c_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=20).
// Accepts, engine handoffs and completions are predicted from the stimulus and
// queued, then popped and compared as the DUT produces them.
module tb_i2c_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int DATA_W         = 16;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int ERR_CNT_W      = 8;

  logic                      clk_i = 1'b0;
  logic                      reset_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_done_o;
  logic                      req_error_o;
  logic                      eng_valid_o;
  logic [DATA_W-1:0]         eng_data_o;
  logic                      eng_ready_i;
  logic                      eng_done_i;
  logic                      eng_error_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;
  logic                      timeout_o;
  logic [ERR_CNT_W-1:0]      err_count_o;

  i2c_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ERR_CNT_W      (ERR_CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .req_done_o  (req_done_o),
    .req_error_o (req_error_o),
    .eng_valid_o (eng_valid_o),
    .eng_data_o  (eng_data_o),
    .eng_ready_i (eng_ready_i),
    .eng_done_i  (eng_done_i),
    .eng_error_i (eng_error_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .err_count_o (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int model_last = NUM_REQ - 1;

  logic [NUM_REQ-1:0] grant_q[$];
  logic               err_q[$];
  logic [DATA_W-1:0]  data_q[$];
  int                 grant_log[$];

  logic [NUM_REQ-1:0] s_ready;
  logic               s_eng_acc;
  logic [NUM_REQ-1:0] s_done;
  int                 req_acc_cyc;
  int                 eng_acc_cyc;
  int                 done_cyc;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Sample everything at the negedge of the current cycle and run the scoreboard.
  task automatic scoreboard_step();
    int p;
    cyc++;
    s_ready   = req_ready_o;
    s_eng_acc = eng_valid_o && eng_ready_i;
    s_done    = req_done_o;
    if (reset_i) begin
      grant_q.delete();
      err_q.delete();
      data_q.delete();
      model_last = NUM_REQ - 1;
      return;
    end
    if (req_ready_o != '0) begin
      p = rr_pick(req_valid_i, model_last);
      if (p < 0) begin
        check_output("ready_without_valid", 32'(req_ready_o), 32'd0);
      end else begin
        check_output("ready_onehot", 32'(req_ready_o), 32'(1 << p));
        model_last = p;
        req_acc_cyc = cyc;
        grant_q.push_back(NUM_REQ'(1 << p));
        data_q.push_back(req_data_i[p*DATA_W +: DATA_W]);
        grant_log.push_back(p);
      end
    end
    if (s_eng_acc) begin
      eng_acc_cyc = cyc;
      if (data_q.size() == 0) check_output("eng_valid_unexpected", 32'(eng_valid_o), 32'd0);
      else check_output("eng_data", 32'(eng_data_o), 32'(data_q.pop_front()));
    end
    if (req_done_o != '0) begin
      done_cyc = cyc;
      if (grant_q.size() == 0) check_output("done_unexpected", 32'(req_done_o), 32'd0);
      else check_output("done_vec", 32'(req_done_o), 32'(grant_q.pop_front()));
      if (err_q.size() == 0) check_output("done_err_expectation", 32'(err_q.size()), 32'd1);
      else check_output("done_err", 32'(req_error_o), 32'(err_q.pop_front()));
    end
  endtask

  // Called at posedge+1; samples this cycle, then advances to the next posedge+1.
  task automatic step();
    @(negedge clk_i);
    scoreboard_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input int idx, input logic [DATA_W-1:0] word);
    bit found;
    found = 0;
    req_valid_i[idx] = 1'b1;
    req_data_i[idx*DATA_W +: DATA_W] = word;
    for (int n = 0; n < 20; n++) begin
      step();
      if (s_ready[idx]) begin
        found = 1;
        break;
      end
    end
    check_output("accept_wait", 32'(found), 32'd1);
    req_valid_i[idx] = 1'b0;
  endtask

  // Engine side of one transaction: wait for the handoff, then answer after
  // 'delay' cycles (or never), and wait for the requester-side done pulse.
  task automatic engine_txn(input int delay, input logic err, input bit send_done,
                            input int exp_lat);
    bit found;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (s_eng_acc) begin
        found = 1;
        break;
      end
    end
    check_output("eng_accept_wait", 32'(found), 32'd1);
    if (send_done) begin
      repeat (delay - 1) step();
      eng_done_i  = 1'b1;
      eng_error_i = err;
      err_q.push_back(err);
      step();
      eng_done_i  = 1'b0;
      eng_error_i = 1'b0;
    end else begin
      err_q.push_back(1'b1);
    end
    found = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (s_done != '0) begin
        found = 1;
        break;
      end
    end
    check_output("done_wait", 32'(found), 32'd1);
    check_output("done_latency", 32'(done_cyc - eng_acc_cyc), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    bit found;
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    eng_ready_i = 1'b1;
    eng_done_i  = 1'b0;
    eng_error_i = 1'b0;
    @(posedge clk_i);
    #1;
    repeat (3) step();

    // Reset state
    check_output("rst_grant", 32'(grant_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_eng_valid", 32'(eng_valid_o), 32'd0);
    check_output("rst_eng_data", 32'(eng_data_o), 32'd0);
    check_output("rst_ready", 32'(req_ready_o), 32'd0);
    check_output("rst_done", 32'(req_done_o), 32'd0);
    check_output("rst_timeout", 32'(timeout_o), 32'd0);
    check_output("rst_err_count", 32'(err_count_o), 32'd0);
    reset_i = 1'b0;
    step();

    // Single request from requester 1
    $display("[TB] single request");
    apply_stimulus(1, 16'h1280);
    check_output("single_ready", 32'(s_ready), 32'h2);
    check_output("single_eng_data", 32'(eng_data_o), 32'h1280);
    check_output("single_grant", 32'(grant_o), 32'h2);
    engine_txn(10, 1'b0, 1'b1, 11);
    check_output("single_issue_latency", 32'(eng_acc_cyc - req_acc_cyc), 32'd1);

    // Contention: both requesters hold valid for four transactions
    $display("[TB] contention");
    grant_log.delete();
    req_data_i  = {16'hB1B1, 16'hA0A0};
    req_valid_i = 2'b11;
    for (int t = 0; t < 4; t++) engine_txn(3, 1'b0, 1'b1, 4);
    req_valid_i = 2'b00;
    check_output("contention_count", 32'(grant_log.size()), 32'd4);
    for (int t = 0; t < 4 && t < grant_log.size(); t++)
      check_output("contention_order", 32'(grant_log[t]), 32'(t % 2));
    check_output("busy_after_contention", 32'(busy_o), 32'd0);

    // Engine NACK
    $display("[TB] engine nack");
    check_output("pre_nack_err_count", 32'(err_count_o), 32'd0);
    apply_stimulus(0, 16'h3A55);
    engine_txn(5, 1'b1, 1'b1, 6);
    check_output("nack_err_count", 32'(err_count_o), 32'd1);
    check_output("nack_timeout", 32'(timeout_o), 32'd0);

    // Done arrives in the timer==0 cycle
    $display("[TB] tie at expiry");
    apply_stimulus(1, 16'h4C01);
    engine_txn(TIMEOUT_CYCLES, 1'b0, 1'b1, TIMEOUT_CYCLES + 1);
    check_output("tie_timeout", 32'(timeout_o), 32'd0);
    check_output("tie_err_count", 32'(err_count_o), 32'd1);

    // Watchdog: engine never answers
    $display("[TB] watchdog");
    apply_stimulus(1, 16'h0F0F);
    engine_txn(0, 1'b1, 1'b0, TIMEOUT_CYCLES + 1);
    check_output("wd_timeout", 32'(timeout_o), 32'd1);
    check_output("wd_err_count", 32'(err_count_o), 32'd2);
    apply_stimulus(0, 16'h1111);
    engine_txn(2, 1'b0, 1'b1, 3);
    check_output("wd_sticky", 32'(timeout_o), 32'd1);

    // Reset while waiting for the engine
    $display("[TB] reset in wait_done");
    apply_stimulus(0, 16'h5A5A);
    found = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_eng_acc) begin
        found = 1;
        break;
      end
    end
    check_output("rwd_eng_accept_wait", 32'(found), 32'd1);
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_output("rwd_grant", 32'(grant_o), 32'd0);
    check_output("rwd_busy", 32'(busy_o), 32'd0);
    check_output("rwd_done", 32'(req_done_o), 32'd0);
    check_output("rwd_eng_valid", 32'(eng_valid_o), 32'd0);
    check_output("rwd_eng_data", 32'(eng_data_o), 32'd0);
    check_output("rwd_timeout", 32'(timeout_o), 32'd0);
    check_output("rwd_err_count", 32'(err_count_o), 32'd0);
    req_data_i  = {16'h7702, 16'h6601};
    req_valid_i = 2'b11;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_ready != '0) begin
        found = 1;
        break;
      end
    end
    check_output("rwd_accept_wait", 32'(found), 32'd1);
    check_output("rwd_winner", 32'(s_ready), 32'h1);
    req_valid_i = 2'b00;
    engine_txn(2, 1'b0, 1'b1, 3);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
